note_sequencer: RTL and testbench

- Pattern-driven note source for one pulse synth channel.
- Owns the channel's control inputs: note_on, note_trigger and phase_inc.
- Steps through a small internal pattern RAM once per song step, i.e. when tick_clk and song_clk are both high in the same cycle.
- Each row is decoded into a trigger, a gate and a tuned phase increment.
- The pattern RAM is loaded by the host through a simple write port.

---
 rtl/note_sequencer.sv | 157 +++++++++++++++
 tb/tb_note_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - pattern-RAM note source driving one pulse channel's gate, trigger and pitch.
// Optional NOTE_SEQ_TRANSPOSE_EN adds a transpose input applied at each song step.
module note_sequencer #(
  parameter int PHASE_BITS = 18,
  parameter int ROW_BITS   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_clk,
  input  logic                  song_clk,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  input  logic                  pat_we,
  input  logic [ROW_BITS-1:0]   pat_addr,
  input  logic [8:0]            pat_data,
`ifdef NOTE_SEQ_TRANSPOSE_EN
  input  logic [3:0]            transpose,
`endif
  output logic                  note_on,
  output logic                  note_trigger,
  output logic [PHASE_BITS-1:0] phase_inc,
  output logic                  busy,
  output logic [ROW_BITS-1:0]   row
);

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_NOTE = 2'b01;
  localparam logic [1:0] CMD_END  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t                r_state;
  logic [8:0]            r_ram [0:(1<<ROW_BITS)-1];
  logic [8:0]            r_cur;
  logic [ROW_BITS-1:0]   r_row_ptr;
  logic                  r_note_on;
  logic [PHASE_BITS-1:0] r_phase_inc;

  logic                  w_step;
  logic [1:0]            w_cmd;
  logic [2:0]            w_oct;
  logic [3:0]            w_semi;
  logic                  w_note_valid;
  logic [ROW_BITS-1:0]   w_next_ptr;
  logic                  w_wrap;
  logic [14:0]           w_shifted;
  logic [PHASE_BITS-1:0] w_pitch;

  function automatic logic [14:0] base_inc(input logic [3:0] semi);
    case (semi)
      4'd0:    base_inc = 15'd11431;
      4'd1:    base_inc = 15'd12110;
      4'd2:    base_inc = 15'd12830;
      4'd3:    base_inc = 15'd13593;
      4'd4:    base_inc = 15'd14402;
      4'd5:    base_inc = 15'd15258;
      4'd6:    base_inc = 15'd16165;
      4'd7:    base_inc = 15'd17127;
      4'd8:    base_inc = 15'd18145;
      4'd9:    base_inc = 15'd19224;
      4'd10:   base_inc = 15'd20367;
      4'd11:   base_inc = 15'd21578;
      default: base_inc = 15'd0;
    endcase
  endfunction

  assign w_step       = tick_clk & song_clk;
  assign w_cmd        = r_cur[8:7];
  assign w_oct        = r_cur[6:4];
  assign w_semi       = r_cur[3:0];
  assign w_note_valid = (w_cmd == CMD_NOTE) && (w_semi < 4'd12);
  assign w_next_ptr   = r_row_ptr + 1'b1;
  assign w_wrap       = (r_row_ptr == {ROW_BITS{1'b1}});

`ifdef NOTE_SEQ_TRANSPOSE_EN
  logic [3:0] w_tr;
  logic [4:0] w_sum;
  logic       w_carry;
  logic [3:0] w_eff_semi;
  logic [3:0] w_eff_oct;

  // Transposition past octave 7 pins to the highest table entry (B7).
  assign w_tr       = (transpose > 4'd11) ? 4'd0 : transpose;
  assign w_sum      = {1'b0, w_semi} + {1'b0, w_tr};
  assign w_carry    = (w_sum >= 5'd12);
  assign w_eff_semi = w_carry ? (w_sum[3:0] - 4'd12) : w_sum[3:0];
  assign w_eff_oct  = {1'b0, w_oct} + {3'd0, w_carry};
  assign w_shifted  = w_eff_oct[3] ? 15'd21578
                                   : (base_inc(w_eff_semi) >> (3'd7 - w_eff_oct[2:0]));
`else
  assign w_shifted  = base_inc(w_semi) >> (3'd7 - w_oct);
`endif

  assign w_pitch = {{(PHASE_BITS-15){1'b0}}, w_shifted};

  always_ff @(posedge clk) begin
    if (pat_we) r_ram[pat_addr] <= pat_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_row_ptr   <= '0;
      r_cur       <= '0;
      r_note_on   <= 1'b0;
      r_phase_inc <= '0;
    end else if (stop) begin
      r_state   <= S_IDLE;
      r_note_on <= 1'b0;
    end else if (start) begin
      r_state   <= S_LOAD;
      r_row_ptr <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_IDLE;
        S_LOAD: begin
          r_cur   <= r_ram[r_row_ptr];
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_cmd == CMD_END) begin
            if (loop && (r_row_ptr != '0)) begin
              r_row_ptr <= '0;
              r_state   <= S_LOAD;
            end else begin
              r_state   <= S_IDLE;
              r_note_on <= 1'b0;
            end
          end else if (w_step) begin
            // OFF rows and out-of-range NOTE rows both close the gate.
            if (w_note_valid) begin
              r_note_on   <= 1'b1;
              r_phase_inc <= w_pitch;
            end else if (w_cmd != CMD_HOLD) begin
              r_note_on <= 1'b0;
            end
            r_row_ptr <= w_next_ptr;
            r_cur     <= r_ram[w_next_ptr];
            if (w_wrap && !loop) begin
              r_state   <= S_IDLE;
              r_note_on <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign note_on      = r_note_on;
  assign note_trigger = (r_state == S_RUN) && w_note_valid;
  assign phase_inc    = r_phase_inc;
  assign busy         = (r_state != S_IDLE);
  assign row          = r_row_ptr;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed bench for note_sequencer with a cycle-level reference model.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, tick_clk, song_clk, start, stop, loop, pat_we;
  logic [4:0]  pat_addr;
  logic [8:0]  pat_data;
  logic        note_on, note_trigger, busy;
  logic [17:0] phase_inc;
  logic [4:0]  row;
`ifdef NOTE_SEQ_TRANSPOSE_EN
  logic [3:0]  transpose;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  note_sequencer #(.PHASE_BITS(18), .ROW_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .tick_clk(tick_clk), .song_clk(song_clk),
    .start(start), .stop(stop), .loop(loop), .pat_we(pat_we),
    .pat_addr(pat_addr), .pat_data(pat_data),
`ifdef NOTE_SEQ_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .note_on(note_on), .note_trigger(note_trigger), .phase_inc(phase_inc),
    .busy(busy), .row(row)
  );

  always #5 clk = ~clk;

  // Reference model: playback mode 0=idle 1=load 2=run
  int         tbl [12] = '{11431, 12110, 12830, 13593, 14402, 15258,
                           16165, 17127, 18145, 19224, 20367, 21578};
  logic [8:0] m_ram [32];
  int         m_mode = 0, m_ptr = 0, m_on = 0, m_inc = 0;
  int         m_cmd_r = 0, m_oct_r = 0, m_semi_r = 0;
  bit         m_valid = 0;

  function automatic int model_pitch(int oct, int semi, int tr);
    int s, o;
    if (tr > 11) tr = 0;
    s = semi + tr;
    o = oct + s / 12;
    s = s % 12;
    if (o > 7) return 21578;
    return tbl[s] >> (7 - o);
  endfunction

  always @(posedge clk) begin
    int tr;
`ifdef NOTE_SEQ_TRANSPOSE_EN
    tr = int'(transpose);
`else
    tr = 0;
`endif
    if (!rst_n) begin
      m_mode = 0; m_ptr = 0; m_on = 0; m_inc = 0;
      m_cmd_r = 0; m_oct_r = 0; m_semi_r = 0; m_valid = 1;
    end else if (stop) begin
      m_mode = 0; m_on = 0;
    end else if (start) begin
      m_mode = 1; m_ptr = 0;
    end else if (m_mode == 1) begin
      m_cmd_r = int'(m_ram[m_ptr] >> 7); m_oct_r = int'((m_ram[m_ptr] >> 4) & 7);
      m_semi_r = int'(m_ram[m_ptr] & 15); m_mode = 2;
    end else if (m_mode == 2) begin
      if (m_cmd_r == 3) begin
        if (loop && m_ptr != 0) begin m_ptr = 0; m_mode = 1; end
        else begin m_mode = 0; m_on = 0; end
      end else if (tick_clk && song_clk) begin
        if (m_cmd_r == 1 && m_semi_r < 12) begin
          m_on = 1; m_inc = model_pitch(m_oct_r, m_semi_r, tr);
        end else if (m_cmd_r != 0) begin
          m_on = 0;
        end
        m_ptr = (m_ptr + 1) % 32;
        m_cmd_r = int'(m_ram[m_ptr] >> 7); m_oct_r = int'((m_ram[m_ptr] >> 4) & 7);
        m_semi_r = int'(m_ram[m_ptr] & 15);
        if (m_ptr == 0 && !loop) begin m_mode = 0; m_on = 0; end
      end
    end
    if (pat_we) m_ram[pat_addr] = pat_data;
  end

  always @(negedge clk) begin
    int exp_trig;
    logic [4:0]  exp_row;
    logic [17:0] exp_inc;
    if (m_valid) begin
      exp_trig = (m_mode == 2 && m_cmd_r == 1 && m_semi_r < 12) ? 1 : 0;
      exp_row  = m_ptr[4:0];
      exp_inc  = m_inc[17:0];
      n_checks++;
      if (note_on !== m_on[0] || note_trigger !== exp_trig[0] || phase_inc !== exp_inc ||
          busy !== (m_mode != 0) || row !== exp_row) begin
        n_fail++;
        $display("FAIL model t=%0t: on=%b trig=%b inc=%0d busy=%b row=%0d expected on=%0d trig=%0d inc=%0d busy=%0d row=%0d",
                 $time, note_on, note_trigger, phase_inc, busy, row,
                 m_on, exp_trig, m_inc, (m_mode != 0), m_ptr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [8:0] d);
    pat_we = 1'b1; pat_addr = a[4:0]; pat_data = d;
    @(negedge clk);
    pat_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic step();
    tick_clk = 1'b1; song_clk = 1'b1;
    @(negedge clk);
    tick_clk = 1'b0; song_clk = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick_clk = 0; song_clk = 0; start = 0; stop = 0; loop = 0;
    pat_we = 0; pat_addr = '0; pat_data = '0;
`ifdef NOTE_SEQ_TRANSPOSE_EN
    transpose = 4'd0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_note_on", note_on, 0);
    chk("reset_trigger", note_trigger, 0);
    chk("reset_phase", phase_inc, 0);
    chk("reset_busy", busy, 0);
    chk("reset_row", row, 0);
    rst_n = 1'b1;

    wr(0, 9'h0C9); wr(1, 9'h000); wr(2, 9'h100); wr(3, 9'h180);
    go();
    chk("basic_trig_s1", note_trigger, 1);
    step();
    chk("basic_phase_s1", phase_inc, 2403);
    chk("basic_on_s1", note_on, 1);
    step();
    chk("basic_trig_s2", note_trigger, 0);
    chk("basic_phase_s2", phase_inc, 2403);
    step();
    chk("basic_on_s3", note_on, 0);
    step();
    chk("basic_busy_end", busy, 0);
    chk("basic_phase_hold", phase_inc, 2403);

    loop = 1'b1;
    go();
    repeat (3) step();
    @(negedge clk);
    chk("loop_row0", row, 0);
    chk("loop_busy", busy, 1);
    @(negedge clk);
    chk("loop_retrig", note_trigger, 1);
    step();
    chk("loop_on", note_on, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_hold_on", note_on, 0);
    chk("stop_hold_busy", busy, 0);

    wr(0, 9'h180);
    go();
    @(negedge clk);
    chk("end_row0_busy", busy, 0);

    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("start_stop_busy", busy, 0);

    loop = 1'b0;
    wr(0, 9'h0F0); wr(1, 9'h0CD); wr(2, 9'h180);
    go();
    chk("c7_trig", note_trigger, 1);
    step();
    chk("c7_phase", phase_inc, 11431);
    chk("semi13_trig", note_trigger, 0);
    step();
    chk("semi13_off", note_on, 0);
    chk("semi13_phase", phase_inc, 11431);
    repeat (2) @(negedge clk);

    wr(0, 9'h0C9);
    for (int i = 1; i < 32; i++) wr(i, 9'h000);
    go();
    repeat (5) step();
    chk("full_row5", row, 5);
    start = 1'b1; tick_clk = 1'b1; song_clk = 1'b1;
    @(negedge clk);
    start = 1'b0; tick_clk = 1'b0; song_clk = 1'b0;
    chk("restart_row", row, 0);
    chk("restart_on_hold", note_on, 1);
    @(negedge clk);
    chk("restart_trig", note_trigger, 1);
    repeat (31) step();
    chk("full_row31", row, 31);
    chk("full_busy31", busy, 1);
    step();
    chk("full_wrap_busy", busy, 0);
    chk("full_wrap_on", note_on, 0);

`ifdef NOTE_SEQ_TRANSPOSE_EN
    wr(0, 9'h0C9); wr(1, 9'h0FB); wr(2, 9'h180);
    transpose = 4'd5;
    go();
    step();
    chk("tr_a4_plus5", phase_inc, 3207);
    transpose = 4'd1;
    step();
    chk("tr_b7_sat", phase_inc, 21578);
    transpose = 4'd0;
    repeat (2) @(negedge clk);
`endif

    wr(0, 9'h0C9); wr(1, 9'h000); wr(2, 9'h180);
    loop = 1'b1;
    go();
    step();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_on", note_on, 0);
    chk("midreset_phase", phase_inc, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_row", row, 0);
    chk("midreset_trig", note_trigger, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
